// File: rtl/uarc_send_scheduler.sv
// Round-robin scheduler for UARC send requests: offers one bus at a time to the
// core as either a WAIT wake-up or an interrupt, and runs the take/ack handshake.
module uarc_send_scheduler #(
    parameter int WORD_WIDTH         = 32,
    parameter int TOTAL_BUSES        = 4,
    parameter int BUS_IDX_WIDTH      = 2,
    parameter int PROGRAM_ADDR_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [TOTAL_BUSES-1:0]            receiver_sends,
    output logic [TOTAL_BUSES-1:0]            receiver_send_acks,
    input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_datas,
    input  logic [TOTAL_BUSES-1:0]            interrupt_enables,
    input  logic [TOTAL_BUSES-1:0]            bus_selections,
    input  logic                              wait_req,
    input  logic                              vec_we,
    input  logic [BUS_IDX_WIDTH-1:0]          vec_index,
    input  logic [PROGRAM_ADDR_WIDTH-1:0]     vec_value,
    output logic                              offer_valid,
    output logic                              offer_mode,
    output logic [BUS_IDX_WIDTH-1:0]          offer_bus,
    output logic [PROGRAM_ADDR_WIDTH-1:0]     offer_address,
    output logic [WORD_WIDTH-1:0]             offer_data,
    input  logic                              offer_take,
    input  logic                              irq_return,
    output logic                              in_service
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                          state_reg;
    logic [BUS_IDX_WIDTH-1:0]        rr_ptr_reg;
    logic                            in_service_reg;
    logic                            offer_valid_reg;
    logic                            offer_mode_reg;
    logic [BUS_IDX_WIDTH-1:0]        offer_bus_reg;
    logic [PROGRAM_ADDR_WIDTH-1:0]   offer_address_reg;
    logic [WORD_WIDTH-1:0]           offer_data_reg;
    logic [TOTAL_BUSES-1:0]          acks_reg;
    logic [PROGRAM_ADDR_WIDTH-1:0]   vector_reg [TOTAL_BUSES];

    logic [TOTAL_BUSES-1:0]          masked;
    logic [TOTAL_BUSES-1:0]          offer_onehot;
    logic                            sel_found;
    logic [BUS_IDX_WIDTH-1:0]        sel_bus;
    logic [WORD_WIDTH-1:0]           sel_data;
    logic [PROGRAM_ADDR_WIDTH-1:0]   sel_vec;
    logic                            offer_still_req;

    // Interrupts are suppressed while a handler runs; WAIT wake-ups are not.
    always_comb begin
        masked = receiver_sends &
                 (wait_req ? bus_selections : (in_service_reg ? '0 : interrupt_enables));
    end

    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_bus   = '0;
        for (int k = 0; k < TOTAL_BUSES; k++) begin
            idx = (int'(rr_ptr_reg) + k) % TOTAL_BUSES;
            if (!sel_found && masked[idx]) begin
                sel_found = 1'b1;
                sel_bus   = BUS_IDX_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_vec  = '0;
        for (int k = 0; k < TOTAL_BUSES; k++) begin
            if (sel_bus == BUS_IDX_WIDTH'(k)) begin
                sel_data = receiver_datas[k*WORD_WIDTH +: WORD_WIDTH];
                sel_vec  = vector_reg[k];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < TOTAL_BUSES; gi++) begin : g_bus
            assign offer_onehot[gi] = (offer_bus_reg == BUS_IDX_WIDTH'(gi));

            // Indices beyond the table never match, so out-of-range writes drop out.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vector_reg[gi] <= '0;
                end else if (vec_we && (vec_index == BUS_IDX_WIDTH'(gi))) begin
                    vector_reg[gi] <= vec_value;
                end
            end
        end
    endgenerate

    assign offer_still_req = |(receiver_sends & offer_onehot);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            rr_ptr_reg        <= '0;
            in_service_reg    <= 1'b0;
            offer_valid_reg   <= 1'b0;
            offer_mode_reg    <= 1'b0;
            offer_bus_reg     <= '0;
            offer_address_reg <= '0;
            offer_data_reg    <= '0;
            acks_reg          <= '0;
        end else begin
            acks_reg <= '0;
            if (irq_return) begin
                in_service_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (sel_found) begin
                        state_reg         <= OFFER;
                        offer_valid_reg   <= 1'b1;
                        offer_bus_reg     <= sel_bus;
                        offer_data_reg    <= sel_data;
                        offer_mode_reg    <= !wait_req;
                        offer_address_reg <= wait_req ? '0 : sel_vec;
                    end
                end
                OFFER: begin
                    if (!offer_still_req) begin
                        state_reg       <= IDLE;
                        offer_valid_reg <= 1'b0;
                    end else if (offer_take) begin
                        state_reg       <= IDLE;
                        offer_valid_reg <= 1'b0;
                        acks_reg        <= offer_onehot;
                        // Placed after the irq_return clear so a coincident take wins.
                        if (offer_mode_reg) begin
                            in_service_reg <= 1'b1;
                        end
                        if (offer_bus_reg == BUS_IDX_WIDTH'(TOTAL_BUSES-1)) begin
                            rr_ptr_reg <= '0;
                        end else begin
                            rr_ptr_reg <= offer_bus_reg + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign receiver_send_acks = acks_reg;
    assign offer_valid        = offer_valid_reg;
    assign offer_mode         = offer_mode_reg;
    assign offer_bus          = offer_bus_reg;
    assign offer_address      = offer_address_reg;
    assign offer_data         = offer_data_reg;
    assign in_service         = in_service_reg;

endmodule
